// File: rtl/exu_cdb_pkg.sv
// Shared types and constants for the writeback arbiter / CDB driver slice.
package exu_cdb_pkg;

  localparam int XLEN      = 64;
  localparam int PREG_W    = 6;
  localparam int IID_W     = 5;
  localparam int NUM_UNITS = 4;

  localparam int UNIT_ALU = 0;
  localparam int UNIT_MXU = 1;
  localparam int UNIT_DIV = 2;
  localparam int UNIT_LSU = 3;

  typedef logic [1:0] unit_idx_t;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [IID_W-1:0]  iid;
    logic [XLEN-1:0]   result;
  } wb_entry_t;

  // Round-robin successor over the four unit slots.
  function automatic unit_idx_t rr_next(input unit_idx_t u);
    return u + 2'd1;
  endfunction

endpackage

// File: rtl/exu_cdb_wb_arb_if.sv
// Unit writeback inputs plus CDB / RF write / RTU completion outputs of the arbiter.
// exu_<u>_wb_vld/rdy: an entry transfers in a cycle where both are high; vld without
// rdy is ignored and the unit keeps holding its data. All outputs are plain valid pulses.
interface exu_cdb_wb_arb_if;
  import exu_cdb_pkg::*;

  logic              exu_alu_wb_vld, exu_mxu_wb_vld, exu_div_wb_vld, exu_lsu_wb_vld;
  logic [PREG_W-1:0] exu_alu_wb_preg, exu_mxu_wb_preg, exu_div_wb_preg, exu_lsu_wb_preg;
  logic [IID_W-1:0]  exu_alu_wb_iid, exu_mxu_wb_iid, exu_div_wb_iid, exu_lsu_wb_iid;
  logic [XLEN-1:0]   exu_alu_wb_result, exu_mxu_wb_result, exu_div_wb_result, exu_lsu_wb_result;
  logic              exu_alu_wb_rdy, exu_mxu_wb_rdy, exu_div_wb_rdy, exu_lsu_wb_rdy;

  logic              exu_idu_rf_alu_cdb_vld, exu_idu_rf_mxu_cdb_vld;
  logic              exu_idu_rf_div_cdb_vld, exu_idu_rf_lsu_cdb_vld;
  logic [PREG_W-1:0] exu_idu_rf_alu_cdb_preg, exu_idu_rf_mxu_cdb_preg;
  logic [PREG_W-1:0] exu_idu_rf_div_cdb_preg, exu_idu_rf_lsu_cdb_preg;
  logic [XLEN-1:0]   exu_idu_rf_alu_cdb_result, exu_idu_rf_mxu_cdb_result;
  logic [XLEN-1:0]   exu_idu_rf_div_cdb_result, exu_idu_rf_lsu_cdb_result;

  logic              x_rf_wb0_vld, x_rf_wb1_vld;
  logic [PREG_W-1:0] x_rf_wb0_preg, x_rf_wb1_preg;
  logic [XLEN-1:0]   x_rf_wb0_data, x_rf_wb1_data;
  logic              exu_rtu_cmplt0_vld, exu_rtu_cmplt1_vld;
  logic [IID_W-1:0]  exu_rtu_cmplt0_iid, exu_rtu_cmplt1_iid;

  modport master (
    output exu_alu_wb_vld, exu_mxu_wb_vld, exu_div_wb_vld, exu_lsu_wb_vld,
    output exu_alu_wb_preg, exu_mxu_wb_preg, exu_div_wb_preg, exu_lsu_wb_preg,
    output exu_alu_wb_iid, exu_mxu_wb_iid, exu_div_wb_iid, exu_lsu_wb_iid,
    output exu_alu_wb_result, exu_mxu_wb_result, exu_div_wb_result, exu_lsu_wb_result,
    input  exu_alu_wb_rdy, exu_mxu_wb_rdy, exu_div_wb_rdy, exu_lsu_wb_rdy,
    input  exu_idu_rf_alu_cdb_vld, exu_idu_rf_mxu_cdb_vld,
    input  exu_idu_rf_div_cdb_vld, exu_idu_rf_lsu_cdb_vld,
    input  exu_idu_rf_alu_cdb_preg, exu_idu_rf_mxu_cdb_preg,
    input  exu_idu_rf_div_cdb_preg, exu_idu_rf_lsu_cdb_preg,
    input  exu_idu_rf_alu_cdb_result, exu_idu_rf_mxu_cdb_result,
    input  exu_idu_rf_div_cdb_result, exu_idu_rf_lsu_cdb_result,
    input  x_rf_wb0_vld, x_rf_wb1_vld, x_rf_wb0_preg, x_rf_wb1_preg,
    input  x_rf_wb0_data, x_rf_wb1_data,
    input  exu_rtu_cmplt0_vld, exu_rtu_cmplt1_vld, exu_rtu_cmplt0_iid, exu_rtu_cmplt1_iid
  );

  modport slave (
    input  exu_alu_wb_vld, exu_mxu_wb_vld, exu_div_wb_vld, exu_lsu_wb_vld,
    input  exu_alu_wb_preg, exu_mxu_wb_preg, exu_div_wb_preg, exu_lsu_wb_preg,
    input  exu_alu_wb_iid, exu_mxu_wb_iid, exu_div_wb_iid, exu_lsu_wb_iid,
    input  exu_alu_wb_result, exu_mxu_wb_result, exu_div_wb_result, exu_lsu_wb_result,
    output exu_alu_wb_rdy, exu_mxu_wb_rdy, exu_div_wb_rdy, exu_lsu_wb_rdy,
    output exu_idu_rf_alu_cdb_vld, exu_idu_rf_mxu_cdb_vld,
    output exu_idu_rf_div_cdb_vld, exu_idu_rf_lsu_cdb_vld,
    output exu_idu_rf_alu_cdb_preg, exu_idu_rf_mxu_cdb_preg,
    output exu_idu_rf_div_cdb_preg, exu_idu_rf_lsu_cdb_preg,
    output exu_idu_rf_alu_cdb_result, exu_idu_rf_mxu_cdb_result,
    output exu_idu_rf_div_cdb_result, exu_idu_rf_lsu_cdb_result,
    output x_rf_wb0_vld, x_rf_wb1_vld, x_rf_wb0_preg, x_rf_wb1_preg,
    output x_rf_wb0_data, x_rf_wb1_data,
    output exu_rtu_cmplt0_vld, exu_rtu_cmplt1_vld, exu_rtu_cmplt0_iid, exu_rtu_cmplt1_iid
  );

endinterface

// File: rtl/exu_cdb_wb_fifo.sv
// Per-unit skid FIFO for completed results; ready derives from the registered count only.
module exu_cdb_wb_fifo
  import exu_cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_clk,
  input  logic      flush,
  input  logic      wr_en,
  input  wb_entry_t wr_entry,
  input  logic      rd_en,
  output logic      rdy,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  // A pop in the same cycle does not free a slot for the incoming push.
  assign rdy   = (count != CW'(DEPTH)) && !flush;
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/exu_cdb_wb_arb.sv
// Writeback arbiter / CDB driver: four unit FIFOs, 2-grant round-robin, registered outputs.
// Optional same-cycle FIFO bypass is enabled with `define EXU_CDB_WB_BYPASS_EN.
module exu_cdb_wb_arb
  import exu_cdb_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_clk,
  input  logic                 rtu_global_flush,
  exu_cdb_wb_arb_if.slave      bus,
  output logic [1:0]           dbg_rr_ptr,
  output logic [NUM_UNITS-1:0] dbg_fifo_empty
);

  logic [NUM_UNITS-1:0] wb_vld, wb_rdy, fifo_empty, fifo_wr, fifo_rd, req, gnt;
  wb_entry_t            wb_in     [NUM_UNITS];
  wb_entry_t            fifo_head [NUM_UNITS];
  wb_entry_t            cand      [NUM_UNITS];
  unit_idx_t            rr_ptr, rr_ptr_nxt, g0, g1;
  logic                 g0_vld, g1_vld;

  logic [NUM_UNITS-1:0]             cdb_vld_q;
  logic [NUM_UNITS-1:0][PREG_W-1:0] cdb_preg_q;
  logic [NUM_UNITS-1:0][XLEN-1:0]   cdb_res_q;
  logic [1:0]                       wb_vld_q;
  wb_entry_t [1:0]                  wb_ent_q;

  assign wb_vld = {bus.exu_lsu_wb_vld, bus.exu_div_wb_vld, bus.exu_mxu_wb_vld, bus.exu_alu_wb_vld};
  assign wb_in[UNIT_ALU] = {bus.exu_alu_wb_preg, bus.exu_alu_wb_iid, bus.exu_alu_wb_result};
  assign wb_in[UNIT_MXU] = {bus.exu_mxu_wb_preg, bus.exu_mxu_wb_iid, bus.exu_mxu_wb_result};
  assign wb_in[UNIT_DIV] = {bus.exu_div_wb_preg, bus.exu_div_wb_iid, bus.exu_div_wb_result};
  assign wb_in[UNIT_LSU] = {bus.exu_lsu_wb_preg, bus.exu_lsu_wb_iid, bus.exu_lsu_wb_result};

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_fifo
    exu_cdb_wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_clk  (rst_clk),
      .flush    (rtu_global_flush),
      .wr_en    (fifo_wr[u]),
      .wr_entry (wb_in[u]),
      .rd_en    (fifo_rd[u]),
      .rdy      (wb_rdy[u]),
      .empty    (fifo_empty[u]),
      .head     (fifo_head[u])
    );
  end

  always_comb begin
    unit_idx_t idx;
    idx        = '0;
    req        = '0;
    gnt        = '0;
    g0         = '0;
    g1         = '0;
    g0_vld     = 1'b0;
    g1_vld     = 1'b0;
    rr_ptr_nxt = rr_ptr;
    for (int u = 0; u < NUM_UNITS; u++) begin
`ifdef EXU_CDB_WB_BYPASS_EN
      // An empty unit may offer its incoming entry directly to arbitration.
      if (fifo_empty[u] && wb_vld[u] && wb_rdy[u]) begin
        req[u]  = 1'b1;
        cand[u] = wb_in[u];
      end else begin
        req[u]  = !fifo_empty[u];
        cand[u] = fifo_head[u];
      end
`else
      req[u]  = !fifo_empty[u];
      cand[u] = fifo_head[u];
`endif
    end
    // First two requesters scanning upward from the rr pointer; none during flush.
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = rr_ptr + unit_idx_t'(k);
      if (req[idx] && !rtu_global_flush) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0     = idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1     = idx;
        end
      end
    end
    if (g0_vld) gnt[g0] = 1'b1;
    if (g1_vld) gnt[g1] = 1'b1;
    if (rtu_global_flush) rr_ptr_nxt = '0;
    else if (g1_vld)      rr_ptr_nxt = rr_next(g1);
    else if (g0_vld)      rr_ptr_nxt = rr_next(g0);
    for (int u = 0; u < NUM_UNITS; u++) begin
      fifo_rd[u] = gnt[u] && !fifo_empty[u];
      fifo_wr[u] = wb_vld[u] && wb_rdy[u] && !(gnt[u] && fifo_empty[u]);
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      rr_ptr     <= '0;
      cdb_vld_q  <= '0;
      cdb_preg_q <= '0;
      cdb_res_q  <= '0;
      wb_vld_q   <= '0;
      wb_ent_q   <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      cdb_vld_q <= gnt;
      for (int u = 0; u < NUM_UNITS; u++) begin
        cdb_preg_q[u] <= gnt[u] ? cand[u].preg   : '0;
        cdb_res_q[u]  <= gnt[u] ? cand[u].result : '0;
      end
      wb_vld_q    <= {g1_vld, g0_vld};
      wb_ent_q[0] <= g0_vld ? cand[g0] : '0;
      wb_ent_q[1] <= g1_vld ? cand[g1] : '0;
    end
  end

  assign dbg_rr_ptr     = rr_ptr;
  assign dbg_fifo_empty = fifo_empty;

  assign bus.exu_alu_wb_rdy = wb_rdy[UNIT_ALU];
  assign bus.exu_mxu_wb_rdy = wb_rdy[UNIT_MXU];
  assign bus.exu_div_wb_rdy = wb_rdy[UNIT_DIV];
  assign bus.exu_lsu_wb_rdy = wb_rdy[UNIT_LSU];

  assign bus.exu_idu_rf_alu_cdb_vld    = cdb_vld_q[UNIT_ALU];
  assign bus.exu_idu_rf_alu_cdb_preg   = cdb_preg_q[UNIT_ALU];
  assign bus.exu_idu_rf_alu_cdb_result = cdb_res_q[UNIT_ALU];
  assign bus.exu_idu_rf_mxu_cdb_vld    = cdb_vld_q[UNIT_MXU];
  assign bus.exu_idu_rf_mxu_cdb_preg   = cdb_preg_q[UNIT_MXU];
  assign bus.exu_idu_rf_mxu_cdb_result = cdb_res_q[UNIT_MXU];
  assign bus.exu_idu_rf_div_cdb_vld    = cdb_vld_q[UNIT_DIV];
  assign bus.exu_idu_rf_div_cdb_preg   = cdb_preg_q[UNIT_DIV];
  assign bus.exu_idu_rf_div_cdb_result = cdb_res_q[UNIT_DIV];
  assign bus.exu_idu_rf_lsu_cdb_vld    = cdb_vld_q[UNIT_LSU];
  assign bus.exu_idu_rf_lsu_cdb_preg   = cdb_preg_q[UNIT_LSU];
  assign bus.exu_idu_rf_lsu_cdb_result = cdb_res_q[UNIT_LSU];

  assign bus.x_rf_wb0_vld       = wb_vld_q[0];
  assign bus.x_rf_wb0_preg      = wb_ent_q[0].preg;
  assign bus.x_rf_wb0_data      = wb_ent_q[0].result;
  assign bus.x_rf_wb1_vld       = wb_vld_q[1];
  assign bus.x_rf_wb1_preg      = wb_ent_q[1].preg;
  assign bus.x_rf_wb1_data      = wb_ent_q[1].result;
  assign bus.exu_rtu_cmplt0_vld = wb_vld_q[0];
  assign bus.exu_rtu_cmplt0_iid = wb_ent_q[0].iid;
  assign bus.exu_rtu_cmplt1_vld = wb_vld_q[1];
  assign bus.exu_rtu_cmplt1_iid = wb_ent_q[1].iid;

endmodule
